mul_seq16: RTL and testbench

- Iterative 16x16 shift-add multiplier, signed or unsigned, for the execute stage's multiply path.
- Feeds a 16-bit carry-lookahead adder once per cycle with the partial-product accumulate, and returns a 32-bit product after a fixed latency.
- Uses a start/busy/done handshake so the pipeline can stall on it.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/add16_cla.sv | 50 +++++
 rtl/mul_seq16.sv | 114 +++++++++++
 tb/tb_mul_seq16.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared state encoding, sizes and operand helper for the iterative multiplier.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int MUL_WIDTH   = 16;
   localparam int MUL_LATENCY = 17;

   // Magnitude of a signed operand; -32768 maps to 0x8000, which still fits unsigned.
   function automatic logic [MUL_WIDTH-1:0] operand_mag(
      input logic [MUL_WIDTH-1:0] val,
      input logic                 is_signed
   );
      if (is_signed && val[MUL_WIDTH-1])
         return ~val + MUL_WIDTH'(1);
      return val;
   endfunction

endpackage

// File: rtl/add16_cla.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups joined by a group lookahead unit.
module add16_cla (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);

   // Carries c1..c3 of a 4-bit lookahead block, fully expanded from c0.
   function automatic logic [2:0] carry3(
      input logic [3:0] g,
      input logic [3:0] p,
      input logic       c0
   );
      carry3[0] = g[0] | (p[0] & c0);
      carry3[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      carry3[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
   endfunction

   function automatic logic gen4(
      input logic [3:0] g,
      input logic [3:0] p
   );
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   logic [15:0] w_g;
   logic [15:0] w_p;
   logic [15:0] w_c;
   logic [3:0]  w_grp_g;
   logic [3:0]  w_grp_p;
   logic [3:0]  w_grp_cin;

   assign w_g = a & b;
   assign w_p = a ^ b;

   for (genvar j = 0; j < 4; j++) begin : g_grp
      assign w_grp_g[j]       = gen4(w_g[4*j +: 4], w_p[4*j +: 4]);
      assign w_grp_p[j]       = &w_p[4*j +: 4];
      assign w_c[4*j]         = w_grp_cin[j];
      assign w_c[4*j+1 +: 3]  = carry3(w_g[4*j +: 4], w_p[4*j +: 4], w_grp_cin[j]);
   end

   assign w_grp_cin[0]   = cin;
   assign w_grp_cin[3:1] = carry3(w_grp_g, w_grp_p, cin);
   assign cout           = gen4(w_grp_g, w_grp_p) | (&w_grp_p & cin);
   assign s              = w_p ^ w_c;

endmodule

// File: rtl/mul_seq16.sv
// Iterative shift-add multiplier: signs folded out on start, one CLA accumulate per CALC
// cycle, sign restored in FIX; fixed 17-cycle start-to-done latency, cancellable.
module mul_seq16
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cancel,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplr;
   logic [WIDTH-1:0]   r_acc_hi;
   logic               r_neg;
   logic               r_done;
   logic [2*WIDTH-1:0] r_product;

   logic               w_accept;
   logic               w_step;
   logic               w_finish;
   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH-1:0]   w_sum_lo;
   logic               w_carry;
   logic [2*WIDTH-1:0] w_raw;
   logic [2*WIDTH-1:0] w_result;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: if (start) w_state_nxt = CALC;
         CALC: begin
            if (cancel)                           w_state_nxt = IDLE;
            else if (r_cnt == CNT_W'(WIDTH - 1))  w_state_nxt = FIX;
         end
         FIX:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state != IDLE);
      w_accept = (r_state == IDLE) && start;
      w_step   = (r_state == CALC) && !cancel;
      w_finish = (r_state == FIX)  && !cancel;
   end

   assign w_addend = r_mplr[0] ? r_mcand : '0;

   add16_cla u_add (
      .a    (r_acc_hi),
      .b    (w_addend),
      .cin  (1'b0),
      .s    (w_sum_lo),
      .cout (w_carry)
   );

   // The adder carry lands in the top bit of acc_hi after the right shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplr   <= '0;
         r_acc_hi <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_mcand  <= operand_mag(a, signed_op);
         r_mplr   <= operand_mag(b, signed_op);
         r_neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
         r_acc_hi <= '0;
         r_cnt    <= '0;
      end else if (w_step) begin
         r_acc_hi <= {w_carry, w_sum_lo[WIDTH-1:1]};
         r_mplr   <= {w_sum_lo[0], r_mplr[WIDTH-1:1]};
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   assign w_raw    = {r_acc_hi, r_mplr};
   assign w_result = r_neg ? (~w_raw + (2*WIDTH)'(1)) : w_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_done <= w_finish;
         if (w_finish) r_product <= w_result;
      end
   end

   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_mul_seq16.sv
// Directed bench for mul_seq16: latency, handshake, cancel, reset and boundary products.
module tb_mul_seq16;
   import mul_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_op;
   logic [15:0] a;
   logic [15:0] b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_seq16 dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .signed_op (signed_op),
      .a         (a),
      .b         (b),
      .cancel    (cancel),
      .busy      (busy),
      .done      (done),
      .product   (product)
   );

   typedef struct packed {
      logic        sgn;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec_t;

   localparam int NVEC = 11;
   localparam vec_t VECS [0:NVEC-1] = '{
      '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1},
      '{1'b1, 16'h8000, 16'h8000, 32'h40000000},
      '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000},
      '{1'b1, 16'hFFF9, 16'h0000, 32'h00000000},
      '{1'b0, 16'h8000, 16'h8000, 32'h40000000},
      '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001},
      '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000},
      '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001},
      '{1'b1, 16'h0003, 16'hFFFE, 32'hFFFFFFFA},
      '{1'b0, 16'h00FF, 16'h0101, 32'h0000FFFF},
      '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF}
   };

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Presents operands for one edge, then scrambles them so stale latching shows up.
   task automatic launch(input logic sgn, input logic [15:0] av, input logic [15:0] bv);
      signed_op = sgn;
      a         = av;
      b         = bv;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      signed_op = ~sgn;
      a         = ~av;
      b         = 16'h0BAD;
   endtask

   // Called one cycle after the accepting edge; optionally pokes start while busy.
   task automatic wait_done(input string tag, input logic [31:0] exp, input bit poke);
      int lat         = 0;
      int busy_cycles = 0;
      check({tag, "_done_low_at_start"}, 32'(done), 32'd0);
      while (!done && lat < 3 * MUL_LATENCY) begin
         if (busy) busy_cycles++;
         if (poke && lat == 5) begin
            start = 1'b1;
            a     = 16'h5A5A;
            b     = 16'hA5A5;
         end else if (poke && lat == 6) begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(MUL_LATENCY));
      check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(MUL_LATENCY));
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      check({tag, "_product"}, product, exp);
   endtask

   task automatic count_done(input string tag, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      check({tag, "_no_done"}, 32'(seen), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0]        rav;
      logic [15:0]        rbv;
      logic               rsg;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0]        rexp;

      rst       = 1'b1;
      start     = 1'b0;
      cancel    = 1'b0;
      signed_op = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", product, 32'd0);
      rst = 1'b0;

      launch(1'b0, 16'hFFFF, 16'hFFFF);
      wait_done("u_ffff", 32'hFFFE0001, 1'b0);
      launch(1'b0, 16'h1234, 16'h0010);
      wait_done("b2b", 32'h00012340, 1'b1);

      for (int i = 0; i < NVEC; i++) begin
         launch(VECS[i].sgn, VECS[i].a, VECS[i].b);
         wait_done($sformatf("vec%0d", i), VECS[i].exp, i[0]);
      end

      launch(1'b0, 16'h1111, 16'h2222);
      repeat (7) begin
         @(posedge clk); #1;
      end
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      check("cancel_busy", 32'(busy), 32'd0);
      check("cancel_done", 32'(done), 32'd0);
      check("cancel_product", product, VECS[NVEC-1].exp);
      count_done("cancel", 20);
      check("cancel_product_held", product, VECS[NVEC-1].exp);
      launch(1'b1, 16'hFFFD, 16'h0005);
      wait_done("after_cancel", 32'hFFFFFFF1, 1'b0);

      launch(1'b0, 16'hFFFF, 16'hFFFF);
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst       = 1'b1;
      start     = 1'b1;
      cancel    = 1'b1;
      signed_op = 1'b0;
      a         = 16'h0003;
      b         = 16'h0003;
      @(posedge clk); #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_product", product, 32'd0);
      rst    = 1'b0;
      start  = 1'b0;
      cancel = 1'b0;
      count_done("midrst", 20);
      check("midrst_idle", 32'(busy), 32'd0);

      for (int i = 0; i < 64; i++) begin
         rsg = 1'($urandom_range(0, 1));
         rav = 16'($urandom);
         rbv = 16'($urandom);
         if (rsg) begin
            sa   = {{16{rav[15]}}, rav};
            sb   = {{16{rbv[15]}}, rbv};
            rexp = sa * sb;
         end else begin
            rexp = {16'd0, rav} * {16'd0, rbv};
         end
         launch(rsg, rav, rbv);
         wait_done($sformatf("rnd%0d_%h_%h_s%0d", i, rav, rbv, rsg), rexp, 1'b0);
      end

      @(posedge clk); #1;
      check("final_done_low", 32'(done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
